// File: rtl/sram_sp_arbiter_2p.sv
// Two-master round-robin front end for the single-port 8192x32 SRAM macro.
// Grants are combinational from req; the response (rvalid/rdata/err) appears
// one cycle after the grant. Out-of-window or misaligned accesses are granted
// but never reach the macro, and they complete with err set.
module sram_sp_arbiter_2p #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,

  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,

  output logic                  sram_cen_o,
  output logic                  sram_gwen_o,
  output logic [3:0]            sram_ben_o,
  output logic [ADDR_WIDTH-1:0] sram_a_o,
  output logic [DATA_WIDTH-1:0] sram_d_o,
  input  logic [DATA_WIDTH-1:0] sram_q_i
);

  // Byte-address bits above this index select the SRAM window.
  localparam int TAG_LSB = ADDR_WIDTH + 2;

  logic                  lp;          // last served master: 0 = m0, 1 = m1
  logic [1:0]            rsp_valid;
  logic                  rsp_we;
  logic                  rsp_err;

  logic                  gnt0;
  logic                  gnt1;
  logic                  any_gnt;
  logic [31:0]           sel_addr;
  logic                  sel_we;
  logic [3:0]            sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  hit;
  logic                  rd_ok;

  // Round-robin grant: on a tie the master that was not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req_i && (!m1_req_i || lp)) begin
        gnt0 = 1'b1;
      end else if (m1_req_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Select the granted master's request fields and classify the access.
  always_comb begin
    sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
    sel_we    = gnt1 ? m1_we_i    : m0_we_i;
    sel_be    = gnt1 ? m1_be_i    : m0_be_i;
    sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
    hit       = (sel_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                (sel_addr[1:0] == 2'b00);
  end

  // Drive the macro only for a granted hit; otherwise park it idle.
  always_comb begin
    sram_cen_o  = 1'b1;
    sram_gwen_o = 1'b1;
    sram_ben_o  = 4'hF;
    sram_a_o    = '0;
    sram_d_o    = '0;
    if (any_gnt && hit) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = ~sel_we;
      sram_ben_o  = sel_we ? ~sel_be : 4'hF;
      sram_a_o    = sel_addr[ADDR_WIDTH+1:2];
      sram_d_o    = sel_wdata;
    end
  end

  // Last-served pointer and response registers, loaded on each grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lp        <= 1'b1;
      rsp_valid <= 2'b00;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= {gnt1, gnt0};
      if (any_gnt) begin
        lp      <= gnt1;
        rsp_we  <= sel_we;
        rsp_err <= ~hit;
      end
    end
  end

  // Responses are masked while rst is high so a grant issued just before
  // reset never surfaces as rvalid.
  assign rd_ok       = ~rst & ~rsp_we & ~rsp_err;
  assign m0_rvalid_o = rsp_valid[0] & ~rst;
  assign m1_rvalid_o = rsp_valid[1] & ~rst;
  assign m0_err_o    = rsp_valid[0] & rsp_err & ~rst;
  assign m1_err_o    = rsp_valid[1] & rsp_err & ~rst;
  assign m0_rdata_o  = (rsp_valid[0] & rd_ok) ? sram_q_i : '0;
  assign m1_rdata_o  = (rsp_valid[1] & rd_ok) ? sram_q_i : '0;

endmodule

// File: tb/tb_sram_sp_arbiter_2p.sv
// Directed bench for sram_sp_arbiter_2p with a behavioural SRAM macro model.
module tb_sram_sp_arbiter_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        sram_cen, sram_gwen;
  logic [3:0]  sram_ben;
  logic [12:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  logic [31:0] mem [0:8191];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_sp_arbiter_2p dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req_i    (m0_req),
    .m0_gnt_o    (m0_gnt),
    .m0_addr_i   (m0_addr),
    .m0_we_i     (m0_we),
    .m0_be_i     (m0_be),
    .m0_wdata_i  (m0_wdata),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m0_err_o    (m0_err),
    .m1_req_i    (m1_req),
    .m1_gnt_o    (m1_gnt),
    .m1_addr_i   (m1_addr),
    .m1_we_i     (m1_we),
    .m1_be_i     (m1_be),
    .m1_wdata_i  (m1_wdata),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .m1_err_o    (m1_err),
    .sram_cen_o  (sram_cen),
    .sram_gwen_o (sram_gwen),
    .sram_ben_o  (sram_ben),
    .sram_a_o    (sram_a),
    .sram_d_o    (sram_d),
    .sram_q_i    (sram_q)
  );

  // SRAM macro model: active-low controls, registered read data.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata);
    m0_req = req; m0_addr = addr; m0_we = we; m0_be = be; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata);
    m1_req = req; m1_addr = addr; m1_we = we; m1_be = be; m1_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'hC0DE_0000 | i;
    sram_q = '0;
    rst = 1'b1;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    cyc();
    cyc();

    // Requests during reset must not be granted or reach the macro.
    set_m0(1, 32'h0010_0010, 0, 4'hF, 0);
    set_m1(1, 32'h0010_0020, 0, 4'hF, 0);
    @(negedge clk);
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_cen", sram_cen, 1);
    chk("rst_gwen", sram_gwen, 1);
    chk("rst_ben", sram_ben, 4'hF);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rvalid1", m1_rvalid, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_err1", m1_err, 0);
    cyc();
    rst = 1'b0;
    set_m1(0, 0, 0, 0, 0);

    // m0 read at 0x0010_0010 -> word 4.
    @(negedge clk);
    chk("rd_gnt0", m0_gnt, 1);
    chk("rd_gnt1", m1_gnt, 0);
    chk("rd_cen", sram_cen, 0);
    chk("rd_gwen", sram_gwen, 1);
    chk("rd_a", sram_a, 13'd4);
    cyc();
    set_m0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_rvalid0", m0_rvalid, 1);
    chk("rd_rdata0", m0_rdata, 32'hC0DE_0004);
    chk("rd_err0", m0_err, 0);
    chk("rd_rvalid1", m1_rvalid, 0);
    cyc();

    // m1 partial write at the top word of the window.
    set_m1(1, 32'h0010_7FFC, 1, 4'b0101, 32'hA5A5_1234);
    @(negedge clk);
    chk("wr_gnt1", m1_gnt, 1);
    chk("wr_cen", sram_cen, 0);
    chk("wr_a", sram_a, 13'h1FFF);
    chk("wr_gwen", sram_gwen, 0);
    chk("wr_ben", sram_ben, 4'b1010);
    chk("wr_d", sram_d, 32'hA5A5_1234);
    cyc();
    set_m1(1, 32'h0010_7FFC, 0, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("wr_rvalid1", m1_rvalid, 1);
    chk("wr_rdata1", m1_rdata, 0);
    chk("wr_err1", m1_err, 0);
    chk("rb_gnt1", m1_gnt, 1);
    cyc();
    set_m1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rb_rvalid1", m1_rvalid, 1);
    chk("rb_rdata1", m1_rdata, 32'hC0A5_1F34);
    cyc();

    // Write with no byte enables: issued with BEN all high, no error.
    set_m0(1, 32'h0010_0014, 1, 4'h0, 32'h1111_1111);
    @(negedge clk);
    chk("be0_cen", sram_cen, 0);
    chk("be0_gwen", sram_gwen, 0);
    chk("be0_ben", sram_ben, 4'hF);
    cyc();
    set_m0(1, 32'h0010_0014, 0, 4'hF, 0);
    @(negedge clk);
    chk("be0_rvalid0", m0_rvalid, 1);
    chk("be0_err0", m0_err, 0);
    cyc();
    set_m0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("be0_rb", m0_rdata, 32'hC0DE_0005);
    cyc();

    // Continuous tie after reset: grants alternate starting with m0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_m0(1, 32'h0010_0000, 0, 4'hF, 0);
    set_m1(1, 32'h0010_0020, 0, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt0_%0d", i), m0_gnt, (i % 2 == 0));
      chk($sformatf("rr_gnt1_%0d", i), m1_gnt, (i % 2 == 1));
      if (i > 0) begin
        chk($sformatf("rr_rv0_%0d", i), m0_rvalid, ((i - 1) % 2 == 0));
        chk($sformatf("rr_rv1_%0d", i), m1_rvalid, ((i - 1) % 2 == 1));
        if ((i - 1) % 2 == 0) chk($sformatf("rr_rd0_%0d", i), m0_rdata, 32'hC0DE_0000);
        else                  chk($sformatf("rr_rd1_%0d", i), m1_rdata, 32'hC0DE_0008);
      end
      cyc();
    end
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rr_last_rv0", m0_rvalid, 0);
    chk("rr_last_rv1", m1_rvalid, 1);
    chk("rr_last_rd1", m1_rdata, 32'hC0DE_0008);
    cyc();

    // Out-of-range and misaligned accesses.
    set_m0(1, 32'h0011_0000, 0, 4'hF, 0);
    @(negedge clk);
    chk("oor_gnt0", m0_gnt, 1);
    chk("oor_cen", sram_cen, 1);
    cyc();
    set_m0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("oor_rvalid0", m0_rvalid, 1);
    chk("oor_err0", m0_err, 1);
    chk("oor_rdata0", m0_rdata, 0);
    cyc();
    set_m1(1, 32'h0010_0002, 0, 4'hF, 0);
    @(negedge clk);
    chk("mis_gnt1", m1_gnt, 1);
    chk("mis_cen", sram_cen, 1);
    cyc();
    set_m1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mis_rvalid1", m1_rvalid, 1);
    chk("mis_err1", m1_err, 1);
    chk("mis_rdata1", m1_rdata, 0);
    cyc();

    // Grant to m0, then reset: response dropped, pointer back to m1.
    set_m0(1, 32'h0010_0010, 0, 4'hF, 0);
    @(negedge clk);
    chk("mr_gnt0", m0_gnt, 1);
    cyc();
    rst = 1'b1;
    set_m0(1, 32'h0010_0010, 0, 4'hF, 0);
    set_m1(1, 32'h0010_0020, 0, 4'hF, 0);
    @(negedge clk);
    chk("mr_rv0_in_rst", m0_rvalid, 0);
    chk("mr_gnt0_in_rst", m0_gnt, 0);
    chk("mr_gnt1_in_rst", m1_gnt, 0);
    chk("mr_cen_in_rst", sram_cen, 1);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rv0_after", m0_rvalid, 0);
    chk("mr_tie_gnt0", m0_gnt, 1);
    chk("mr_tie_gnt1", m1_gnt, 0);
    cyc();
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr_tie_rv0", m0_rvalid, 1);
    chk("mr_tie_rd0", m0_rdata, 32'hC0DE_0004);
    cyc();

    // Four back-to-back m0 reads of words 0x10..0x13.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_m0(1, 32'h0010_0040 + 32'(4 * i), 0, 4'hF, 0);
      else       set_m0(0, 0, 0, 0, 0);
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("b2b_gnt0_%0d", i), m0_gnt, 1);
        chk($sformatf("b2b_a_%0d", i), sram_a, 13'h10 + 13'(i));
      end
      if (i > 0) begin
        chk($sformatf("b2b_rv0_%0d", i), m0_rvalid, 1);
        chk($sformatf("b2b_rd0_%0d", i), m0_rdata, 32'hC0DE_0010 + 32'(i - 1));
      end
      cyc();
    end
    @(negedge clk);
    chk("b2b_rv0_end", m0_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
